// File: rtl/proc_pkg.sv
// proc_pkg: shared widths and fetch-state encoding for the 3BC program counter
package proc_pkg;
    localparam int ADDR_W    = 10;
    localparam int OFF_W     = 6;
    localparam int LUT_IDX_W = 5;
    localparam int CNT_W     = 16;
    typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;
endpackage

// File: rtl/prog_counter_if.sv
// prog_counter_if: control inputs and fetch outputs of the program counter
interface prog_counter_if;
    import proc_pkg::*;
    logic                 Start;
    logic [ADDR_W-1:0]    StartAddr;
    logic                 HaltReq;
    logic                 Stall;
    logic                 BranchEn;
    logic [OFF_W-1:0]     BranchOff;
    logic                 JumpEn;
    logic [LUT_IDX_W-1:0] JumpIdx;
    logic [ADDR_W-1:0]    InstAddress;
    logic                 Running;
    logic                 Done;
    logic [CNT_W-1:0]     CycleCount;
    modport master (
        output Start, StartAddr, HaltReq, Stall, BranchEn, BranchOff, JumpEn, JumpIdx,
        input  InstAddress, Running, Done, CycleCount
    );
    modport slave (
        input  Start, StartAddr, HaltReq, Stall, BranchEn, BranchOff, JumpEn, JumpIdx,
        output InstAddress, Running, Done, CycleCount
    );
endinterface

// File: rtl/prog_counter_jump_lut.sv
// jump_lut: read-only jump-target table, combinational lookup
module jump_lut
    import proc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LUT_INIT [2**LUT_IDX_W] = '{default: '0}
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [ADDR_W-1:0]    target
);
    assign target = LUT_INIT[idx];
endmodule

// File: rtl/prog_counter.sv
// prog_counter: fetch-stage PC with start/halt handshake and run-cycle counter
module prog_counter
    import proc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LUT_INIT [2**LUT_IDX_W] = '{default: '0}
) (
    input  logic          Clk,
    input  logic          Reset_n,
    prog_counter_if.slave bus
);
    pc_state_t         state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, jump_target, branch_target;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    jump_lut #(.LUT_INIT(LUT_INIT)) u_lut (
        .idx    (bus.JumpIdx),
        .target (jump_target)
    );

    assign branch_target   = pc + ADDR_W'(signed'(bus.BranchOff));
    assign bus.InstAddress = pc;
    assign bus.Running     = state == RUN;
    assign bus.Done        = state == HALT;
    assign bus.CycleCount  = cnt;

    // state, PC and counter registers; reset wins over everything
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Start restarts from any state; in RUN: halt > stall > jump > branch > increment
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        if (bus.Start) begin
            state_nxt = RUN;
            pc_nxt    = bus.StartAddr;
            cnt_nxt   = '0;
        end else if (state == RUN) begin
            cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
            if (bus.HaltReq) state_nxt = HALT;
            else if (!bus.Stall) pc_nxt = bus.JumpEn ? jump_target :
                                          bus.BranchEn ? branch_target : pc + ADDR_W'(1);
        end
    end
endmodule
